inst_decode_queue: RTL and testbench



---
 rtl/inst_decode_queue.sv | 104 ++++++++++
 tb/tb_inst_decode_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/inst_decode_queue.sv
// MIPS instruction decode queue: classifies R/I/J, splits all fields, extends the immediate and buffers it in a FIFO.
// Optional feature macro DECODE_SIGN_EXT_EN: sign-extend the immediate for arithmetic, branch and load/store opcodes.
module inst_decode_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_fmt,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_funct,
  output logic [DATA_W-1:0]          out_imm,
  output logic [25:0]                out_target,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm;
    logic [25:0]       target;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        dec, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, sext;

  always_comb begin
    dec        = '0;
    dec.opcode = in_inst[31:26];
    dec.rs     = in_inst[25:21];
    dec.rt     = in_inst[20:16];
    dec.rd     = in_inst[15:11];
    dec.shamt  = in_inst[10:6];
    dec.funct  = in_inst[5:0];
    dec.target = in_inst[25:0];
    case (in_inst[31:26])
      6'h00:        dec.fmt = 2'd0;
      6'h02, 6'h03: dec.fmt = 2'd2;
      default:      dec.fmt = 2'd1;
    endcase
`ifdef DECODE_SIGN_EXT_EN
    case (in_inst[31:26])
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B: sext = 1'b1;
      default:                                         sext = 1'b0;
    endcase
`else
    sext = 1'b0;
`endif
    // casting a signed 16-bit value up to DATA_W replicates bit 15
    dec.imm = sext ? DATA_W'($signed(in_inst[15:0])) : DATA_W'(in_inst[15:0]);
  end

  assign in_ready  = !rst && !flush && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // fields read as zero whenever the queue is empty
  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign out_fmt    = head.fmt;
  assign out_opcode = head.opcode;
  assign out_rs     = head.rs;
  assign out_rt     = head.rt;
  assign out_rd     = head.rd;
  assign out_shamt  = head.shamt;
  assign out_funct  = head.funct;
  assign out_imm    = head.imm;
  assign out_target = head.target;
endmodule

// File: tb/tb_inst_decode_queue.sv
module tb_inst_decode_queue;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [1:0]  out_fmt;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [31:0] out_imm;
  logic [25:0] out_target;
  logic [1:0]  count;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_imm;

  always #5 clk = ~clk;

  inst_decode_queue #(.DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fmt(out_fmt), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct),
    .out_imm(out_imm), .out_target(out_target), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    n_err++;
    $error("FAIL timeout: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0;
    tick(); tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b0 ||
        out_fmt !== 2'd0 || out_target !== 26'h0) begin
      n_err++;
      $error("FAIL rst_state: valid=%0b count=%0d ready=%0b fmt=%0d target=%0h",
             out_valid, count, in_ready, out_fmt, out_target);
    end
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 2'd0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_opcode", out_opcode, 6'h0);

    rst = 1'b0; in_valid = 1'b1; in_inst = 32'h2128FFFC; out_ready = 1'b1; #1;
    chk("ready_after_rst", in_ready, 1'b1);
    tick(); in_valid = 1'b0; #1;
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_fmt", out_fmt, 2'd1);
    chk("addi_opcode", out_opcode, 6'h08);
    chk("addi_rs", out_rs, 5'd9);
    chk("addi_rt", out_rt, 5'd8);
`ifdef DECODE_SIGN_EXT_EN
    exp_imm = 32'hFFFFFFFC;
`else
    exp_imm = 32'h0000FFFC;
`endif
    chk("addi_imm", out_imm, exp_imm);
    chk("addi_count", count, 2'd1);
    tick();
    chk("addi_drained", out_valid, 1'b0);

    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h012A4020;
    tick(); in_inst = 32'h0C100010;
    tick(); in_valid = 1'b0; #1;
    chk("add_fmt", out_fmt, 2'd0);
    chk("add_rd", out_rd, 5'd8);
    chk("add_funct", out_funct, 6'h20);
    chk("rj_count", count, 2'd2);
    out_ready = 1'b1;
    tick();
    chk("jal_fmt", out_fmt, 2'd2);
    chk("jal_target", out_target, 26'h0100010);
    chk("jal_count", count, 2'd1);
    tick();
    chk("rj_empty", count, 2'd0);

    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h20010001;
    tick(); in_inst = 32'h20020002;
    tick(); in_inst = 32'h20030003; #1;
    chk("full_count", count, 2'd2);
    chk("full_ready", in_ready, 1'b0);
    tick();
    chk("held_count", count, 2'd2);
    chk("held_head", out_imm, 32'h1);
    out_ready = 1'b1; #1;
    chk("full_ready_pop", in_ready, 1'b0);
    tick();
    chk("drain1_head", out_imm, 32'h2);
    chk("drain1_count", count, 2'd1);
    chk("drain1_ready", in_ready, 1'b1);
    tick(); in_valid = 1'b0; #1;
    chk("third_head", out_imm, 32'h3);
    chk("third_count", count, 2'd1);
    tick();
    chk("bp_empty", count, 2'd0);

    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_inst = 32'h24000000 | k;
      tick();
      n_cmp++;
      if (count !== 2'd1) begin
        n_err++;
        $error("FAIL stream_count[%0d]: got %0h want 1", k, count);
      end
      n_cmp++;
      if (out_imm !== 32'(k)) begin
        n_err++;
        $error("FAIL stream_imm[%0d]: got %0h want %0h", k, out_imm, k);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_empty", count, 2'd0);

    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h1000FFFF;
    tick(); in_inst = 32'h3421FFFF;
    tick(); #1;
`ifdef DECODE_SIGN_EXT_EN
    exp_imm = 32'hFFFFFFFF;
`else
    exp_imm = 32'h0000FFFF;
`endif
    chk("beq_imm", out_imm, exp_imm);
    chk("pre_flush_count", count, 2'd2);
    in_inst = 32'h20070007; flush = 1'b1; out_ready = 1'b1; #1;
    chk("flush_ready", in_ready, 1'b0);
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_count", count, 2'd0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_imm", out_imm, 32'h0);
    chk("flush_target", out_target, 26'h0);
    tick();
    chk("flush_no_enq", count, 2'd0);

    in_valid = 1'b1; out_ready = 1'b0; in_inst = 32'h20050005;
    tick(); in_valid = 1'b0; #1;
    chk("pre_rst_count", count, 2'd1);
    rst = 1'b1; #1;
    chk("midrst_ready", in_ready, 1'b0);
    tick();
    chk("midrst_count", count, 2'd0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ready2", in_ready, 1'b0);
    rst = 1'b0; #1;
    chk("post_rst_ready", in_ready, 1'b1);
    tick();
    chk("post_rst_count", count, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
